sim_test_monitor: RTL and testbench
===================================

Name: sim_test_monitor

Overview:
- Parametrised, cycle-accurate test-completion monitor for soc simulation.
- Snoops the register-file write port of each hart; detects the "test done" flag register and the "pass" register.
- Waits a fixed drain window, then asserts sticky pass/fail/timeout status and a per-hart failure bitmap.
- Bench-level and soc-level checkers use these status outputs instead of peeking hierarchical register arrays. Also usable as an on-chip self-test status block.

Parameters:
- NUM_HARTS, 1, number of independent cores monitored
- XLEN, 32, register data width
- DONE_REG, 26, register index whose write of 1 flags test completion (s10)
- PASS_REG, 27, register index whose value 1 at evaluation means pass (s11)
- RESULT_REG, 28, register index captured for reporting (t3)
- DRAIN_CYCLES, 50, cycles waited after all harts are done before evaluation; must be >=1, elaboration error otherwise
- TIMEOUT_CYCLES, 5000, cycles after reset release at which the test is declared timed out
- CNT_W, 32, cycle counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rf_we_i  in  NUM_HARTS  per-hart register-file write enable
- rf_waddr_i  in  5*NUM_HARTS  per-hart write index; hart h occupies bits [5h+4:5h]
- rf_wdata_i  in  XLEN*NUM_HARTS  per-hart write data
- done_o  out  1  evaluation complete, sticky
- pass_o  out  1  all harts passed, valid when done_o=1
- timeout_o  out  1  timeout occurred, sticky
- fail_hart_o  out  NUM_HARTS  bit h=1 means hart h failed or never finished; valid when done_o=1
- result_o  out  XLEN*NUM_HARTS  last value written to RESULT_REG, per hart
- cycle_cnt_o  out  CNT_W  cycles since reset release; freezes in S_DONE

Behaviour:
- Reset is asynchronous. All outputs, per-hart shadows, counters and the FSM clear to 0 / S_RUN. Reset asserted mid-test aborts everything immediately; no residue remains after release.
- Per-hart capture, every cycle, in S_RUN and S_DRAIN only:
  - Writes with waddr==0 are ignored.
  - we && waddr==DONE_REG && wdata==1 sets sticky done_seen[h]. A later write of any value does not clear it.
  - we && waddr==PASS_REG loads pass_val[h]<=wdata; the last write wins, including writes during the drain window.
  - we && waddr==RESULT_REG loads result[h]<=wdata. result_o is driven directly from these registers.
- FSM:
  - S_RUN: cycle_cnt increments each cycle. When &done_seen is 1 (registered), go to S_DRAIN and load drain_cnt=DRAIN_CYCLES-1.
  - S_DRAIN: cycle_cnt keeps incrementing; drain_cnt decrements. When drain_cnt==0, go to S_DONE and evaluate.
  - Timeout: in S_RUN or S_DRAIN, if cycle_cnt==TIMEOUT_CYCLES-1, go to S_DONE with timeout_o=1 and pass_o=0. Timeout has priority over a same-cycle drain completion or done detection.
  - S_DONE: terminal state; all outputs held until reset. Captures are frozen.
- Evaluation, registered on entry to S_DONE, so outputs appear the cycle after the deciding edge:
  - fail_hart_o[h] = ~done_seen[h] | (pass_val[h]!=1).
  - pass_o = ~timeout & ~|fail_hart_o.
  - done_o=1.
- Latency: the DONE_REG write at edge N sets done_seen at N. With a single hart, S_DRAIN is entered at N+1 and done_o rises at N+1+DRAIN_CYCLES.
- cycle_cnt saturates at all-ones (unreachable given the CNT_W rule).

Optional Feature:
- SIM_TEST_MONITOR_TRACE_EN:
  - When defined, the block prints, for every captured write, one line with $time, hart, register index and data. On entry to S_DONE it prints PASS/FAIL/TIMEOUT plus per-hart result, pass_val and done_seen.
  - When undefined, there are no system tasks and the block is synthesizable; port behaviour is identical.

Decomposition:
- Shared package/include holds:
  - state encodings S_RUN=2'd0, S_DRAIN=2'd1, S_DONE=2'd2
  - register index defaults REG_S10=26, REG_S11=27, REG_T3=28
  - the default DRAIN/TIMEOUT constants
- Sub-module sim_test_monitor_hart, instantiated NUM_HARTS times in a generate loop:
  - inputs: one hart's write port and a capture-enable
  - owns done_seen, pass_val and result
  - the top level holds only the FSM, the counters and the evaluation.

Test Plan:
- NUM_HARTS=1, DRAIN=50. Write x27=1 at cycle 100, x26=1 at cycle 120 → done_o rises at cycle 171, pass_o=1, fail_hart_o=0, timeout_o=0.
- NUM_HARTS=1. Write x26=1, then x27=0 during the drain window → done_o=1, pass_o=0, fail_hart_o=1'b1.
- NUM_HARTS=2. Hart0 completes with pass; hart1 never writes x26; TIMEOUT=5000 → at cycle 5000 done_o=1, timeout_o=1, pass_o=0, fail_hart_o=2'b10, cycle_cnt_o frozen at 4999.
- Write x28=0xDEADBEEF then x28=0x0000_1234; also write x0 with 1 and x26=2 → result_o=0x00001234; done_seen stays clear (index 0 and value 2 are ignored), so the test ends by timeout.
- Pull rst_n low for 3 cycles while in S_DRAIN → all outputs are 0 asynchronously. After release, a fresh pass sequence completes normally with cycle_cnt_o restarting from 0.
- Set the drain countdown to expire on the same edge as TIMEOUT_CYCLES-1 → timeout_o=1, pass_o=0.

Source files
------------

// File: rtl/sim_test_monitor_pkg.sv
// Shared state encodings and default register indices / timing constants
// for the simulation test-completion monitor.
package sim_test_monitor_pkg;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // RISC-V ABI names of the default flag registers
  localparam int REG_S10 = 26;
  localparam int REG_S11 = 27;
  localparam int REG_T3  = 28;

  localparam int DRAIN_CYCLES_DEF   = 50;
  localparam int TIMEOUT_CYCLES_DEF = 5000;

endpackage

// File: rtl/sim_test_monitor_hart.sv
// Per-hart snoop of one register-file write port: sticky done flag, last
// pass-register value and last result-register value.
module sim_test_monitor_hart
  import sim_test_monitor_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int DONE_REG   = REG_S10,
  parameter int PASS_REG   = REG_S11,
  parameter int RESULT_REG = REG_T3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cap_en,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  output logic            done_seen,
  output logic [XLEN-1:0] pass_val,
  output logic [XLEN-1:0] result
);

  logic hit;

  // x0 is hard-wired zero on the core, so writes to it never count
  assign hit = cap_en && we && (waddr != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_seen <= 1'b0;
      pass_val  <= '0;
      result    <= '0;
    end else if (hit) begin
      if (waddr == 5'(DONE_REG) && wdata == XLEN'(1))
        done_seen <= 1'b1;
      if (waddr == 5'(PASS_REG))
        pass_val <= wdata;
      if (waddr == 5'(RESULT_REG))
        result <= wdata;
    end
  end

endmodule

// File: rtl/sim_test_monitor.sv
// Test-completion monitor: waits for every hart's done flag, drains, then
// latches sticky pass/fail/timeout status. Optional write/verdict trace
// printing is enabled by defining SIM_TEST_MONITOR_TRACE_EN.
module sim_test_monitor
  import sim_test_monitor_pkg::*;
#(
  parameter int NUM_HARTS      = 1,
  parameter int XLEN           = 32,
  parameter int DONE_REG       = REG_S10,
  parameter int PASS_REG       = REG_S11,
  parameter int RESULT_REG     = REG_T3,
  parameter int DRAIN_CYCLES   = DRAIN_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_HARTS-1:0]      rf_we_i,
  input  logic [5*NUM_HARTS-1:0]    rf_waddr_i,
  input  logic [XLEN*NUM_HARTS-1:0] rf_wdata_i,
  output logic                      done_o,
  output logic                      pass_o,
  output logic                      timeout_o,
  output logic [NUM_HARTS-1:0]      fail_hart_o,
  output logic [XLEN*NUM_HARTS-1:0] result_o,
  output logic [CNT_W-1:0]          cycle_cnt_o
);

  localparam int DR_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [DR_W-1:0]  DRAIN_LAST   = DR_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  if (DRAIN_CYCLES < 1) begin : g_bad_drain
    $error("sim_test_monitor: DRAIN_CYCLES must be >= 1");
  end
  if ($clog2(TIMEOUT_CYCLES + 1) > CNT_W) begin : g_bad_cnt_w
    $error("sim_test_monitor: CNT_W too narrow for TIMEOUT_CYCLES");
  end

  state_t                 state, state_next;
  logic [CNT_W-1:0]       cycle_cnt, cnt_next;
  logic [DR_W-1:0]        drain_cnt, drain_next;
  logic                   eval, to_timeout, cap_en, all_done;
  logic [NUM_HARTS-1:0]   done_seen, fail_vec;
  logic [XLEN-1:0]        pass_val [NUM_HARTS];

  assign cap_en   = (state == S_RUN) || (state == S_DRAIN);
  assign all_done = &done_seen;

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    sim_test_monitor_hart #(
      .XLEN       (XLEN),
      .DONE_REG   (DONE_REG),
      .PASS_REG   (PASS_REG),
      .RESULT_REG (RESULT_REG)
    ) u_hart (
      .clk       (clk),
      .rst_n     (rst_n),
      .cap_en    (cap_en),
      .we        (rf_we_i[h]),
      .waddr     (rf_waddr_i[5*h +: 5]),
      .wdata     (rf_wdata_i[XLEN*h +: XLEN]),
      .done_seen (done_seen[h]),
      .pass_val  (pass_val[h]),
      .result    (result_o[XLEN*h +: XLEN])
    );
  end

  always_comb begin
    fail_vec = '0;
    for (int h = 0; h < NUM_HARTS; h++)
      fail_vec[h] = ~done_seen[h] | (pass_val[h] != XLEN'(1));
  end

  // Next-state: timeout outranks both done detection and drain expiry
  always_comb begin
    state_next = state;
    drain_next = drain_cnt;
    cnt_next   = cycle_cnt;
    eval       = 1'b0;
    to_timeout = 1'b0;
    case (state)
      S_RUN, S_DRAIN: begin
        if (cycle_cnt == TIMEOUT_LAST) begin
          state_next = S_DONE;
          eval       = 1'b1;
          to_timeout = 1'b1;
        end else if (state == S_RUN) begin
          if (all_done) begin
            state_next = S_DRAIN;
            drain_next = DRAIN_LAST;
          end
        end else if (drain_cnt == '0) begin
          state_next = S_DONE;
          eval       = 1'b1;
        end else begin
          drain_next = drain_cnt - 1'b1;
        end
        // counter freezes on the edge that enters S_DONE
        if (state_next != S_DONE && cycle_cnt != {CNT_W{1'b1}})
          cnt_next = cycle_cnt + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RUN;
      cycle_cnt <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      cycle_cnt <= cnt_next;
      drain_cnt <= drain_next;
    end
  end

  // Verdict registered on the edge that enters S_DONE, then held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      timeout_o   <= 1'b0;
      fail_hart_o <= '0;
    end else if (eval) begin
      done_o      <= 1'b1;
      timeout_o   <= to_timeout;
      fail_hart_o <= fail_vec;
      pass_o      <= ~to_timeout & ~|fail_vec;
    end
  end

  assign cycle_cnt_o = cycle_cnt;

`ifdef SIM_TEST_MONITOR_TRACE_EN
  always @(posedge clk) begin
    if (rst_n && cap_en) begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (rf_we_i[h] && rf_waddr_i[5*h +: 5] != 5'd0 &&
            (rf_waddr_i[5*h +: 5] == 5'(DONE_REG) ||
             rf_waddr_i[5*h +: 5] == 5'(PASS_REG) ||
             rf_waddr_i[5*h +: 5] == 5'(RESULT_REG)))
          $display("%0t sim_test_monitor: hart %0d x%0d <= 0x%0h", $time, h,
                   rf_waddr_i[5*h +: 5], rf_wdata_i[XLEN*h +: XLEN]);
      end
    end
    if (rst_n && eval) begin
      if (to_timeout)
        $display("%0t sim_test_monitor: TIMEOUT", $time);
      else if (fail_vec == '0)
        $display("%0t sim_test_monitor: PASS", $time);
      else
        $display("%0t sim_test_monitor: FAIL", $time);
      for (int h = 0; h < NUM_HARTS; h++)
        $display("  hart %0d result=0x%0h pass_val=0x%0h done_seen=%0b", h,
                 result_o[XLEN*h +: XLEN], pass_val[h], done_seen[h]);
    end
  end
`else
  // synthesizable build: no trace output
`endif

endmodule

// File: tb/tb_sim_test_monitor.sv
// Directed bench for sim_test_monitor: a single-hart and a two-hart instance
// driven from one sequence of scenario tasks.
module tb_sim_test_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        we1 = 1'b0;
  logic [4:0]  waddr1 = '0;
  logic [31:0] wdata1 = '0;
  logic        done1, pass1, timeout1;
  logic [0:0]  fail1;
  logic [31:0] result1, cyc1;

  logic [1:0]  we2 = '0;
  logic [9:0]  waddr2 = '0;
  logic [63:0] wdata2 = '0;
  logic        done2, pass2, timeout2;
  logic [1:0]  fail2;
  logic [63:0] result2;
  logic [31:0] cyc2;

  int n_cmp = 0;
  int n_fail = 0;
  int tb_cyc;

  always #5 clk = ~clk;

  // edge number since reset release
  always @(posedge clk or negedge rst_n)
    if (!rst_n) tb_cyc <= 0;
    else        tb_cyc <= tb_cyc + 1;

  sim_test_monitor #(.NUM_HARTS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rf_we_i(we1), .rf_waddr_i(waddr1),
    .rf_wdata_i(wdata1), .done_o(done1), .pass_o(pass1), .timeout_o(timeout1),
    .fail_hart_o(fail1), .result_o(result1), .cycle_cnt_o(cyc1)
  );

  sim_test_monitor #(.NUM_HARTS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .rf_we_i(we2), .rf_waddr_i(waddr2),
    .rf_wdata_i(wdata2), .done_o(done2), .pass_o(pass2), .timeout_o(timeout2),
    .fail_hart_o(fail2), .result_o(result2), .cycle_cnt_o(cyc2)
  );

  task automatic wait_edge(input int n);
    while (tb_cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    we1 = 1'b0; waddr1 = '0; wdata1 = '0;
    we2 = '0;   waddr2 = '0; wdata2 = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // write sampled at edge n
  task automatic wr1(input logic [4:0] a, input logic [31:0] d, input int n);
    wait_edge(n - 1);
    we1 = 1'b1; waddr1 = a; wdata1 = d;
    wait_edge(n);
    we1 = 1'b0; waddr1 = '0; wdata1 = '0;
  endtask

  task automatic wr2(input int h, input logic [4:0] a, input logic [31:0] d, input int n);
    wait_edge(n - 1);
    we2 = '0; waddr2 = '0; wdata2 = '0;
    we2[h] = 1'b1;
    waddr2[5*h +: 5] = a;
    wdata2[32*h +: 32] = d;
    wait_edge(n);
    we2 = '0; waddr2 = '0; wdata2 = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({done1, pass1, timeout1, fail1} !== 4'b0) begin
      n_fail++; $display("FAIL reset_status: got %b want 0000", {done1, pass1, timeout1, fail1});
    end
    n_cmp++;
    if (result1 !== 32'h0 || cyc1 !== 32'd0) begin
      n_fail++; $display("FAIL reset_regs: got result=%0h cnt=%0d want 0/0", result1, cyc1);
    end
    wait_edge(1);
    n_cmp++;
    if (cyc1 !== 32'd1) begin
      n_fail++; $display("FAIL first_count: got %0d want 1", cyc1);
    end
  endtask

  task automatic test_pass();
    do_reset();
    wr1(5'd27, 32'd1, 100);
    wr1(5'd26, 32'd1, 120);
    wait_edge(170);
    n_cmp++;
    if (done1 !== 1'b0) begin
      n_fail++; $display("FAIL pass_early: got done=%b want 0", done1);
    end
    wait_edge(171);
    n_cmp++;
    if ({done1, pass1, timeout1, fail1} !== 4'b1100) begin
      n_fail++; $display("FAIL pass_status: got %b want 1100", {done1, pass1, timeout1, fail1});
    end
    wait_edge(180);
    n_cmp++;
    if (cyc1 !== 32'd170 || done1 !== 1'b1) begin
      n_fail++; $display("FAIL pass_frozen: got cnt=%0d done=%b want 170/1", cyc1, done1);
    end
  endtask

  task automatic test_drain_fail();
    do_reset();
    wr1(5'd27, 32'd1, 10);
    wr1(5'd26, 32'd1, 20);
    wr1(5'd27, 32'd0, 40);
    wait_edge(71);
    n_cmp++;
    if ({done1, pass1, timeout1, fail1} !== 4'b1001) begin
      n_fail++; $display("FAIL drain_fail: got %b want 1001", {done1, pass1, timeout1, fail1});
    end
  endtask

  task automatic test_timeout_2hart();
    do_reset();
    wr2(0, 5'd27, 32'd1, 10);
    wr2(0, 5'd26, 32'd1, 20);
    wait_edge(4999);
    n_cmp++;
    if (done2 !== 1'b0 || cyc2 !== 32'd4999) begin
      n_fail++; $display("FAIL to2_before: got done=%b cnt=%0d want 0/4999", done2, cyc2);
    end
    wait_edge(5000);
    n_cmp++;
    if ({done2, pass2, timeout2} !== 3'b101) begin
      n_fail++; $display("FAIL to2_status: got %b want 101", {done2, pass2, timeout2});
    end
    n_cmp++;
    if (fail2 !== 2'b10) begin
      n_fail++; $display("FAIL to2_fail_hart: got %b want 10", fail2);
    end
    wait_edge(5010);
    n_cmp++;
    if (cyc2 !== 32'd4999) begin
      n_fail++; $display("FAIL to2_frozen: got %0d want 4999", cyc2);
    end
  endtask

  task automatic test_result_ignore();
    do_reset();
    wr1(5'd28, 32'hDEADBEEF, 10);
    wr1(5'd28, 32'h00001234, 11);
    wr1(5'd0,  32'd1, 12);
    wr1(5'd26, 32'd2, 13);
    wait_edge(14);
    n_cmp++;
    if (result1 !== 32'h00001234) begin
      n_fail++; $display("FAIL result_last: got %0h want 1234", result1);
    end
    wait_edge(100);
    n_cmp++;
    if (done1 !== 1'b0) begin
      n_fail++; $display("FAIL ignore_done: got done=%b want 0", done1);
    end
    wait_edge(5000);
    n_cmp++;
    if ({done1, pass1, timeout1, fail1} !== 4'b1011) begin
      n_fail++; $display("FAIL ignore_timeout: got %b want 1011", {done1, pass1, timeout1, fail1});
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    wr1(5'd28, 32'h55, 5);
    wr1(5'd27, 32'd1, 10);
    wr1(5'd26, 32'd1, 20);
    wait_edge(30);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (result1 !== 32'h0 || cyc1 !== 32'd0 || {done1, pass1, timeout1, fail1} !== 4'b0) begin
      n_fail++; $display("FAIL async_reset: got result=%0h cnt=%0d st=%b want 0/0/0000",
                         result1, cyc1, {done1, pass1, timeout1, fail1});
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_edge(5);
    n_cmp++;
    if (cyc1 !== 32'd5 || result1 !== 32'h0) begin
      n_fail++; $display("FAIL restart: got cnt=%0d result=%0h want 5/0", cyc1, result1);
    end
    wr1(5'd27, 32'd1, 10);
    wr1(5'd26, 32'd1, 20);
    wait_edge(70);
    n_cmp++;
    if (done1 !== 1'b0) begin
      n_fail++; $display("FAIL restart_early: got done=%b want 0", done1);
    end
    wait_edge(71);
    n_cmp++;
    if ({done1, pass1, timeout1, fail1} !== 4'b1100) begin
      n_fail++; $display("FAIL restart_pass: got %b want 1100", {done1, pass1, timeout1, fail1});
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    wr1(5'd27, 32'd1, 4900);
    wr1(5'd26, 32'd1, 4949);
    wait_edge(4999);
    n_cmp++;
    if (done1 !== 1'b0) begin
      n_fail++; $display("FAIL simul_early: got done=%b want 0", done1);
    end
    wait_edge(5000);
    n_cmp++;
    if ({done1, pass1, timeout1, fail1} !== 4'b1010) begin
      n_fail++; $display("FAIL simul_priority: got %b want 1010", {done1, pass1, timeout1, fail1});
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_drain_fail();
    test_timeout_2hart();
    test_result_ignore();
    test_reset_mid_drain();
    test_simultaneous();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
